maxpool2x2_stream: RTL and testbench

Streaming 2×2, stride-2 max-pooling stage placed directly downstream of the ReLU activation array in the food-classification CNN datapath. It accepts one activation pixel per cycle in raster order (row-major, R rows × C columns) and emits one pooled pixel for every 2×2 window, giving an (R/2)×(C/2) output map. A half-row line buffer holds partial maxima, so the block never stores a full feature map.

---
 rtl/maxpool2x2_stream.sv | 131 +++++++++++++
 tb/tb_maxpool2x2_stream.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream
// Streaming 2x2 / stride-2 max pooling over an R x C raster-order activation
// map. One pixel may be accepted per cycle (no backpressure). Horizontal pairs
// are reduced in h_q. Even-row pair maxima are parked in a C/2-entry line
// buffer. Odd-row pair maxima are combined with that buffer to produce one
// pooled pixel per 2x2 window.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - synchronous active-low reset (priority over in_valid)
//   in_valid   - data_in carries a pixel this cycle; low = stall, state holds
//   data_in    - signed pixel at the current (row, col)
//   out_valid  - one-cycle pulse, data_out carries a pooled pixel
//   data_out   - signed max of one 2x2 window; holds when out_valid=0
//   frame_done - one-cycle pulse with the last pooled pixel of a frame
module maxpool2x2_stream #(
  parameter int data_width = 32,
  parameter int R          = 4,
  parameter int C          = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [data_width-1:0] data_in,
  output logic                  out_valid,
  output logic [data_width-1:0] data_out,
  output logic                  frame_done
);

  localparam int RW = $clog2(R);
  localparam int CW = $clog2(C);
  localparam int HC = C / 2;
  localparam int LW = (HC > 1) ? $clog2(HC) : 1;

  // Signed maximum; on a tie either operand is the same value.
  function automatic logic [data_width-1:0] smax(
    input logic [data_width-1:0] a,
    input logic [data_width-1:0] b
  );
    logic [data_width-1:0] m;
    if ($signed(a) >= $signed(b)) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [data_width-1:0] h_q, h_d;
  logic                  out_valid_q, out_valid_d;
  logic [data_width-1:0] data_out_q, data_out_d;
  logic                  frame_done_q, frame_done_d;

  logic [data_width-1:0] line_buf_q [HC];
  logic                  lb_we_d;
  logic [LW-1:0]         lb_idx_d;
  logic [data_width-1:0] hmax_d;

  // Next-state: position counters, horizontal/vertical reduction, outputs.
  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    h_d          = h_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    data_out_d   = data_out_q;
    lb_we_d      = 1'b0;
    lb_idx_d     = LW'(col_q >> 1);
    hmax_d       = smax(h_q, data_in);

    if (in_valid) begin
      if (col_q[0] == 1'b0) begin
        h_d = data_in;
      end else if (row_q[0] == 1'b0) begin
        // Even row: park the pair maximum until the odd row arrives.
        lb_we_d = 1'b1;
      end else begin
        out_valid_d  = 1'b1;
        data_out_d   = smax(line_buf_q[lb_idx_d], hmax_d);
        frame_done_d = (row_q == RW'(R - 1)) && (col_q == CW'(C - 1));
      end

      if (col_q == CW'(C - 1)) begin
        col_d = {CW{1'b0}};
        if (row_q == RW'(R - 1)) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q        <= {RW{1'b0}};
      col_q        <= {CW{1'b0}};
      h_q          <= {data_width{1'b0}};
      out_valid_q  <= 1'b0;
      data_out_q   <= {data_width{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      h_q          <= h_d;
      out_valid_q  <= out_valid_d;
      data_out_q   <= data_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer: always written on an even row before being read, so no reset.
  always_ff @(posedge clk) begin
    if (rst_n && lb_we_d) begin
      line_buf_q[lb_idx_d] <= hmax_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign data_out   = data_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream: a 4x4 instance (a) and a 2x6
// instance (b). Expected pooled values come from the full input map held in
// frame_px, indexed by (row, col) of each accepted pixel.
module tb_maxpool2x2_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid_a, in_valid_b;
  logic [31:0] data_in_a, data_in_b;
  logic        out_valid_a, out_valid_b;
  logic [31:0] data_out_a, data_out_b;
  logic        frame_done_a, frame_done_b;

  int checks;
  int failures;
  int frame_px [0:63];
  int last_out [0:1];

  maxpool2x2_stream #(.data_width(32), .R(4), .C(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .data_in(data_in_a),
    .out_valid(out_valid_a), .data_out(data_out_a), .frame_done(frame_done_a)
  );

  maxpool2x2_stream #(.data_width(32), .R(2), .C(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .data_in(data_in_b),
    .out_valid(out_valid_b), .data_out(data_out_b), .frame_done(frame_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check_out(input int which, input string tag, input logic ev,
                           input int ed, input logic edone);
    logic        ov, fd;
    logic [31:0] dout;
    logic [31:0] exp_d;
    if (which == 0) begin
      ov = out_valid_a; dout = data_out_a; fd = frame_done_a;
    end else begin
      ov = out_valid_b; dout = data_out_b; fd = frame_done_b;
    end
    exp_d = ev ? ed : last_out[which];
    checks++;
    assert (ov === ev) else begin
      failures++;
      $error("FAIL %s out_valid observed=%0b expected=%0b", tag, ov, ev);
    end
    checks++;
    assert (dout === exp_d) else begin
      failures++;
      $error("FAIL %s data_out observed=%0d expected=%0d", tag, $signed(dout), $signed(exp_d));
    end
    checks++;
    assert (fd === edone) else begin
      failures++;
      $error("FAIL %s frame_done observed=%0b expected=%0b", tag, fd, edone);
    end
    if (ev) last_out[which] = ed;
  endtask

  task automatic step(input int which, input string tag, input logic v,
                      input logic [31:0] d, input logic ev, input int ed,
                      input logic edone);
    if (which == 0) begin
      in_valid_a = v; data_in_a = d;
    end else begin
      in_valid_b = v; data_in_b = d;
    end
    @(posedge clk);
    #1;
    check_out(which, tag, ev, ed, edone);
  endtask

  task automatic reset_cycle(input string tag);
    rst_n = 1'b0;
    in_valid_a = 1'b1;
    data_in_a = $urandom;
    in_valid_b = 1'b1;
    data_in_b = $urandom;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    last_out[0] = 0;
    last_out[1] = 0;
    check_out(0, tag, 1'b0, 0, 1'b0);
    check_out(1, tag, 1'b0, 0, 1'b0);
  endtask

  // Feed the first npix pixels of frame_px (rows x cols map), with stalls.
  task automatic run_frame(input int which, input string tag, input int rows,
                           input int cols, input int npix, input int stall_pct);
    int r, c, w;
    logic ev, edone;
    for (int k = 0; k < npix; k++) begin
      while ($urandom_range(99, 0) < stall_pct) begin
        step(which, {tag, "_stall"}, 1'b0, $urandom, 1'b0, 0, 1'b0);
      end
      r = k / cols;
      c = k % cols;
      ev = ((r % 2) == 1) && ((c % 2) == 1);
      w = 0;
      if (ev) begin
        w = max2(max2(frame_px[(r-1)*cols + c-1], frame_px[(r-1)*cols + c]),
                 max2(frame_px[r*cols + c-1],     frame_px[r*cols + c]));
      end
      edone = ev && (k == rows * cols - 1);
      step(which, tag, 1'b1, frame_px[k], ev, w, edone);
    end
  endtask

  task automatic idle(input int which, input string tag, input int n);
    for (int i = 0; i < n; i++) step(which, tag, 1'b0, $urandom, 1'b0, 0, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid_a = 1'b0; data_in_a = 32'd0;
    in_valid_b = 1'b0; data_in_b = 32'd0;
    last_out[0] = 0; last_out[1] = 0;
    @(posedge clk);
    reset_cycle("reset_init");

    // Basic 4x4 frame 1..16, continuous.
    for (int i = 0; i < 16; i++) frame_px[i] = i + 1;
    run_frame(0, "basic", 4, 4, 16, 0);
    idle(0, "basic_idle", 2);

    // Signed compare: window (1,1) is -5,-3,-7,-1, all else 0.
    for (int i = 0; i < 16; i++) frame_px[i] = 0;
    frame_px[10] = -5; frame_px[11] = -3; frame_px[14] = -7; frame_px[15] = -1;
    run_frame(0, "signed", 4, 4, 16, 0);
    idle(0, "signed_idle", 1);

    // Same 1..16 frame with ~40% stalls.
    for (int i = 0; i < 16; i++) frame_px[i] = i + 1;
    run_frame(0, "stall", 4, 4, 16, 40);
    idle(0, "stall_idle", 1);

    // Back-to-back frames: 1..16 then 16..1, no gap.
    run_frame(0, "b2b_a", 4, 4, 16, 0);
    for (int i = 0; i < 16; i++) frame_px[i] = 16 - i;
    run_frame(0, "b2b_b", 4, 4, 16, 0);
    idle(0, "b2b_idle", 1);

    // Reset mid-frame after 6 pixels, then a clean frame.
    for (int i = 0; i < 16; i++) frame_px[i] = i + 1;
    run_frame(0, "partial", 4, 4, 6, 0);
    reset_cycle("reset_mid");
    idle(0, "post_reset_idle", 2);
    run_frame(0, "after_reset", 4, 4, 16, 0);
    idle(0, "after_reset_idle", 1);

    // Randomized frames with signed values and stalls.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) frame_px[i] = $urandom;
      run_frame(0, "random", 4, 4, 16, 30);
    end
    idle(0, "random_idle", 1);

    // 2x6 variant: 1..12 then random frames.
    for (int i = 0; i < 12; i++) frame_px[i] = i + 1;
    run_frame(1, "r2c6", 2, 6, 12, 0);
    idle(1, "r2c6_idle", 1);
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 12; i++) frame_px[i] = $urandom;
      run_frame(1, "r2c6_random", 2, 6, 12, 30);
    end
    idle(1, "r2c6_random_idle", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
